conv_loop_scheduler: RTL and testbench
======================================

CONV_LOOP_SCHEDULER -- requirements
Module: conv_loop_scheduler

Interface
REQ-001 SHALL have parameter I_MAX, default 4, i loop trip count (1..255).
REQ-002 SHALL have parameter J_MAX, default 16, j loop trip count (1..255).
REQ-003 SHALL have parameter K_MAX, default 8, k loop trip count (1..255).
REQ-004 SHALL have parameter BURST, default 16, beats per tile (power of two, 2..256).
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, begin one full loop nest.
REQ-008 SHALL have port ready, input, 1, consumer accepts current beat.
REQ-009 SHALL have ports i, j, k, output, 8 each, current tile indices to the weight address generator.
REQ-010 SHALL have port gen_en, output, 1, one-cycle pulse that launches the address generator for a tile.
REQ-011 SHALL have port valid, output, 1, beat in progress.
REQ-012 SHALL have port beat, output, $clog2(BURST), beat index within tile.
REQ-013 SHALL have ports busy (level) and done (one-cycle pulse), output, 1 each.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, BURST, NEXT, DONE; all transitions on rising clk.
REQ-015 IDLE SHALL go to LOAD when start=1; otherwise stay; i=j=k=0 on entry.
REQ-016 LOAD SHALL assert gen_en for exactly one cycle, then go to BURST with beat=0.
REQ-017 BURST SHALL hold valid=1; beat increments only in cycles with ready=1; ready=0 holds beat and state.
REQ-018 BURST SHALL go to NEXT in the cycle after the beat=BURST-1 beat is accepted; beat wraps to 0.
REQ-019 NEXT SHALL advance indices with i innermost, j middle, k outermost: i+1; i wraps at I_MAX to 0 carrying into j; j wraps at J_MAX carrying into k.
REQ-020 NEXT SHALL go to DONE if i=I_MAX-1, j=J_MAX-1, k=K_MAX-1 (last tile), else to LOAD; indices after the last tile SHALL remain at their final values.
REQ-021 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-022 busy SHALL be 1 in LOAD, BURST, NEXT, DONE and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored and not queued.
REQ-024 valid SHALL be 0 outside BURST; gen_en SHALL be 0 outside LOAD.
REQ-025 With ready held 1, one tile SHALL take BURST+2 cycles; full nest I_MAX*J_MAX*K_MAX*(BURST+2)+1 cycles from start sample to done pulse, inclusive.
REQ-026 start and the last accepted beat in the same cycle SHALL not affect sequencing (start ignored).

Reset
REQ-027 rst=1 SHALL force IDLE and i=j=k=0, beat=0, gen_en=valid=busy=done=0 immediately, including mid-burst.
REQ-028 After rst deasserts, the block SHALL wait for a new start; no partial nest resumes.

Configuration
REQ-029 Macro SCHED_PAUSE_EN defined SHALL add input port pause (1 bit).
REQ-030 With SCHED_PAUSE_EN, pause=1 in any non-IDLE state SHALL freeze state, indices and beat, and force valid=gen_en=done=0; pending pulses issue after pause drops.
REQ-031 With SCHED_PAUSE_EN, pause=1 in IDLE SHALL not block start acceptance.
REQ-032 Without SCHED_PAUSE_EN, port pause SHALL not exist and behaviour SHALL be as if pause=0.

Verification
REQ-033 I_MAX=2,J_MAX=2,K_MAX=2,BURST=4, ready=1, start pulse -> 8 gen_en pulses, (i,j,k) order (0,0,0),(1,0,0),(0,1,0)...(1,1,1), done 49 cycles after start.
REQ-034 Same config, ready toggled 1/0 each cycle -> beats 0..3 each held during ready=0, 32 accepted beats total, done once.
REQ-035 rst asserted at tile (1,0,0) beat 2 -> all outputs 0 same cycle; new start restarts at (0,0,0).
REQ-036 start pulsed during BURST -> no effect; exactly one done per nest.
REQ-037 Defaults (4,16,8,16) ready=1 -> 512 tiles, last indices (3,15,7), done at cycle 9217.
REQ-038 SCHED_PAUSE_EN, pause=1 for 5 cycles mid-BURST -> valid=0, beat frozen, done delayed exactly 5 cycles.

Source files
------------

// File: rtl/conv_loop_scheduler.sv
// rtl/conv_loop_scheduler.sv - i/j/k tile loop-nest sequencer driving a weight address generator and beat bursts
// Optional feature macro: SCHED_PAUSE_EN (adds the pause input that freezes a running nest)
module conv_loop_scheduler #(
    parameter int I_MAX = 4,
    parameter int J_MAX = 16,
    parameter int K_MAX = 8,
    parameter int BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ready,
`ifdef SCHED_PAUSE_EN
    input  logic                     pause,
`endif
    output logic [7:0]               i,
    output logic [7:0]               j,
    output logic [7:0]               k,
    output logic                     gen_en,
    output logic                     valid,
    output logic [$clog2(BURST)-1:0] beat,
    output logic                     busy,
    output logic                     done
);

    localparam int BW = $clog2(BURST);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0]    I_LAST    = 8'(I_MAX - 1);
    localparam logic [7:0]    J_LAST    = 8'(J_MAX - 1);
    localparam logic [7:0]    K_LAST    = 8'(K_MAX - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

    logic [2:0] state;
    logic       hold;
    logic       last_tile;
    logic       last_beat;

    // Pause never applies in IDLE, so a start can always be taken there.
`ifdef SCHED_PAUSE_EN
    assign hold = pause && (state != S_IDLE);
`else
    assign hold = 1'b0;
`endif

    assign last_tile = (i == I_LAST) && (j == J_LAST) && (k == K_LAST);
    assign last_beat = (beat == BEAT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            beat  <= '0;
        end else if (!hold) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        i     <= 8'd0;
                        j     <= 8'd0;
                        k     <= 8'd0;
                    end
                end
                S_LOAD: begin
                    state <= S_BURST;
                    beat  <= '0;
                end
                S_BURST: begin
                    if (ready) begin
                        if (last_beat) begin
                            beat  <= '0;
                            state <= S_NEXT;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                S_NEXT: begin
                    // The final tile keeps its indices so they are visible while done pulses.
                    if (last_tile) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_LOAD;
                        if (i == I_LAST) begin
                            i <= 8'd0;
                            if (j == J_LAST) begin
                                j <= 8'd0;
                                k <= k + 8'd1;
                            end else begin
                                j <= j + 8'd1;
                            end
                        end else begin
                            i <= i + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    i     <= 8'd0;
                    j     <= 8'd0;
                    k     <= 8'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign gen_en = (state == S_LOAD)  && !hold;
    assign valid  = (state == S_BURST) && !hold;
    assign done   = (state == S_DONE)  && !hold;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// tb/tb_conv_loop_scheduler.sv - directed self-checking bench for conv_loop_scheduler (2x2x2x4 and default configs)
module tb_conv_loop_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_d;
    logic       ready;
`ifdef SCHED_PAUSE_EN
    logic       pause;
`endif

    logic [7:0] i, j, k;
    logic       gen_en, valid, busy, done;
    logic [1:0] beat;

    logic [7:0] i_d, j_d, k_d;
    logic       gen_en_d, valid_d, busy_d, done_d;
    logic [3:0] beat_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_loop_scheduler #(.I_MAX(2), .J_MAX(2), .K_MAX(2), .BURST(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
`ifdef SCHED_PAUSE_EN
        .pause(pause),
`endif
        .i(i), .j(j), .k(k), .gen_en(gen_en), .valid(valid), .beat(beat),
        .busy(busy), .done(done)
    );

    conv_loop_scheduler dut_d (
        .clk(clk), .rst(rst), .start(start_d), .ready(ready),
`ifdef SCHED_PAUSE_EN
        .pause(1'b0),
`endif
        .i(i_d), .j(j_d), .k(k_d), .gen_en(gen_en_d), .valid(valid_d), .beat(beat_d),
        .busy(busy_d), .done(done_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one nest on the 2x2x2x4 instance; start is sampled at the edge right after cycle 0.
    task automatic run_nest(input int ready_mode, input int start_at, input int pause_at,
                            output int done_cyc, output int tiles, output int acc, output int dones);
        int c;
        int exp_beat;
        c = 0; exp_beat = 0; tiles = 0; acc = 0; dones = 0; done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        while (c < 400 && !(done_cyc >= 0 && c >= done_cyc + 3)) begin
            @(negedge clk);
            c++;
            start = (c == start_at);
            ready = (ready_mode == 0) ? 1'b1 : c[0];
`ifdef SCHED_PAUSE_EN
            pause = (pause_at > 0 && c >= pause_at && c < pause_at + 5);
            #1;
            if (pause) check("pause_valid", {31'd0, valid}, 32'd0);
`endif
            if (gen_en) begin
                check("tile_ijk", {8'd0, i, j, k},
                      {8'd0, 8'(tiles % 2), 8'((tiles / 2) % 2), 8'(tiles / 4)});
                tiles++;
            end
            if (valid) begin
                check("beat_idx", {30'd0, beat}, 32'(exp_beat));
                if (ready) begin
                    exp_beat = (exp_beat + 1) % 4;
                    acc++;
                end
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
        end
        start = 1'b0;
`ifdef SCHED_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

    initial begin
        int dc, tl, ac, dn, c;
        int tiles_d, done_cyc_d;
        logic [23:0] last_ijk_d;

        rst = 1'b1; start = 1'b0; start_d = 1'b0; ready = 1'b1;
`ifdef SCHED_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_outs", {8'd0, i, j, k, 2'd0, beat, gen_en, valid, busy, done}, 32'd0);
        check("reset_outs_d", {i_d, j_d, k_d, beat_d, gen_en_d, valid_d, busy_d, done_d}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Plain nest with ready held high.
        run_nest(0, 0, 0, dc, tl, ac, dn);
        check("n1_done_cycle", 32'(dc), 32'd49);
        check("n1_tiles", 32'(tl), 32'd8);
        check("n1_beats", 32'(ac), 32'd32);
        check("n1_dones", 32'(dn), 32'd1);
        check("n1_idle_after", {31'd0, busy}, 32'd0);
        check("n1_ijk_cleared", {8'd0, i, j, k}, 32'd0);

        // Ready toggling each cycle.
        run_nest(1, 0, 0, dc, tl, ac, dn);
        check("n2_tiles", 32'(tl), 32'd8);
        check("n2_beats", 32'(ac), 32'd32);
        check("n2_dones", 32'(dn), 32'd1);

        // Start coincides with the last beat of tile 0: ignored, timing unchanged.
        run_nest(0, 5, 0, dc, tl, ac, dn);
        check("n3_done_cycle", 32'(dc), 32'd49);
        check("n3_dones", 32'(dn), 32'd1);

        // Start pulsed mid-burst of a later tile.
        run_nest(0, 16, 0, dc, tl, ac, dn);
        check("n4_done_cycle", 32'(dc), 32'd49);
        check("n4_dones", 32'(dn), 32'd1);

        // Reset during tile (1,0,0) beat 2.
        @(negedge clk);
        start = 1'b1; ready = 1'b1;
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_state", {8'd0, i, j, k, 2'd0, beat, gen_en, valid, busy, done},
              {8'd0, 8'd1, 8'd0, 8'd0, 2'd0, 2'd2, 4'b0110});
        rst = 1'b1;
        #1;
        check("rst_immediate", {8'd0, i, j, k, 2'd0, beat, gen_en, valid, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_resume", {30'd0, busy, gen_en}, 32'd0);
        run_nest(0, 0, 0, dc, tl, ac, dn);
        check("n5_done_cycle", 32'(dc), 32'd49);
        check("n5_tiles", 32'(tl), 32'd8);

`ifdef SCHED_PAUSE_EN
        // Five paused cycles mid-burst push done out by exactly five.
        run_nest(0, 0, 20, dc, tl, ac, dn);
        check("n6_done_cycle", 32'(dc), 32'd54);
        check("n6_beats", 32'(ac), 32'd32);
        check("n6_dones", 32'(dn), 32'd1);
`endif

        // Default configuration full nest.
        tiles_d = 0; done_cyc_d = -1; last_ijk_d = '0;
        @(negedge clk);
        start_d = 1'b1; ready = 1'b1;
        for (c = 1; c <= 10000 && done_cyc_d < 0; c++) begin
            @(negedge clk);
            start_d = 1'b0;
            if (gen_en_d) tiles_d++;
            if (done_d) begin
                done_cyc_d = c;
                last_ijk_d = {i_d, j_d, k_d};
            end
        end
        check("def_done_cycle", 32'(done_cyc_d), 32'd9217);
        check("def_tiles", 32'(tiles_d), 32'd512);
        check("def_last_ijk", {8'd0, last_ijk_d}, {8'd0, 8'd3, 8'd15, 8'd7});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
